// File: rtl/ysyx_25020037_axi_arbiter_pkg.sv
// Shared encodings for the IFU/LSU AXI arbiter: FSM states, master indices, AXI response codes.
package ysyx_25020037_axi_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IFU_RD = 2'd1;
  localparam logic [1:0] ST_LSU_RD = 2'd2;
  localparam logic [1:0] ST_LSU_WR = 2'd3;

  localparam int M_IFU = 0;
  localparam int M_LSU = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_25020037_rr_arb2.sv
// Two-way round-robin picker; remembers the last winner and favours the other master on a tie.
module ysyx_25020037_rr_arb2
  import ysyx_25020037_axi_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  logic r_last;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'(M_IFU);
    end else if (i_update && (|o_gnt)) begin
      r_last <= o_gnt[M_LSU];
    end
  end

endmodule

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Shares one AXI4 port between IFU (read-only) and LSU (read/write), one whole transaction at a time.
// Grant is registered; channel routing is a combinational mux on the current state.
module ysyx_25020037_axi_arbiter
  import ysyx_25020037_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [ID_W-1:0]     ifu_arid,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [1:0]          ifu_rresp,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rlast,
  output logic [ID_W-1:0]     ifu_rid,
  input  logic                ifu_rready,
  // LSU read
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [ID_W-1:0]     lsu_arid,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic [1:0]          lsu_arburst,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic [1:0]          lsu_rresp,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rlast,
  output logic [ID_W-1:0]     lsu_rid,
  input  logic                lsu_rready,
  // LSU write
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [ID_W-1:0]     lsu_awid,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic [1:0]          lsu_awburst,
  output logic                lsu_awready,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  output logic [ID_W-1:0]     lsu_bid,
  input  logic                lsu_bready,
  // toward xbar
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [1:0]          s_rresp,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  output logic                s_rready,
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_wready,
  input  logic                s_bvalid,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid,
  output logic                s_bready,
  output logic [CNT_W-1:0]    contention_cnt
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_contend;
  logic [CNT_W-1:0] r_cnt;

  // LSU never issues AR and AW together; if it does, the write wins below.
  assign w_req = {lsu_arvalid | lsu_awvalid, ifu_arvalid};

  ysyx_25020037_rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_update (r_state == ST_IDLE),
    .o_gnt    (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt[M_LSU])      w_state_nxt = lsu_awvalid ? ST_LSU_WR : ST_LSU_RD;
        else if (w_gnt[M_IFU]) w_state_nxt = ST_IFU_RD;
      end
      ST_IFU_RD: if (s_rvalid && ifu_rready && s_rlast) w_state_nxt = ST_IDLE;
      ST_LSU_RD: if (s_rvalid && lsu_rready && s_rlast) w_state_nxt = ST_IDLE;
      ST_LSU_WR: if (s_bvalid && lsu_bready)            w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A cycle counts when the master not owning the port is asking for it.
  always_comb begin
    case (r_state)
      ST_IDLE:   w_contend = &w_req;
      ST_IFU_RD: w_contend = w_req[M_LSU];
      default:   w_contend = w_req[M_IFU];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (w_contend && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end

  assign contention_cnt = r_cnt;

  always_comb begin
    s_arvalid   = 1'b0;  s_araddr  = '0; s_arid    = '0; s_arlen   = '0;
    s_arsize    = '0;    s_arburst = '0; s_rready  = 1'b0;
    s_awvalid   = 1'b0;  s_awaddr  = '0; s_awid    = '0; s_awlen   = '0;
    s_awsize    = '0;    s_awburst = '0;
    s_wvalid    = 1'b0;  s_wdata   = '0; s_wstrb   = '0; s_wlast   = 1'b0;
    s_bready    = 1'b0;
    ifu_arready = 1'b0;  ifu_rvalid = 1'b0; ifu_rresp = RESP_OKAY;
    ifu_rdata   = '0;    ifu_rlast  = 1'b0; ifu_rid   = '0;
    lsu_arready = 1'b0;  lsu_rvalid = 1'b0; lsu_rresp = RESP_OKAY;
    lsu_rdata   = '0;    lsu_rlast  = 1'b0; lsu_rid   = '0;
    lsu_awready = 1'b0;  lsu_wready = 1'b0;
    lsu_bvalid  = 1'b0;  lsu_bresp  = RESP_OKAY; lsu_bid = '0;
    case (r_state)
      ST_IFU_RD: begin
        s_arvalid   = ifu_arvalid;  s_araddr  = ifu_araddr;  s_arid    = ifu_arid;
        s_arlen     = ifu_arlen;    s_arsize  = ifu_arsize;  s_arburst = ifu_arburst;
        ifu_arready = s_arready;
        ifu_rvalid  = s_rvalid;     ifu_rresp = s_rresp;     ifu_rdata = s_rdata;
        ifu_rlast   = s_rlast;      ifu_rid   = s_rid;       s_rready  = ifu_rready;
      end
      ST_LSU_RD: begin
        s_arvalid   = lsu_arvalid;  s_araddr  = lsu_araddr;  s_arid    = lsu_arid;
        s_arlen     = lsu_arlen;    s_arsize  = lsu_arsize;  s_arburst = lsu_arburst;
        lsu_arready = s_arready;
        lsu_rvalid  = s_rvalid;     lsu_rresp = s_rresp;     lsu_rdata = s_rdata;
        lsu_rlast   = s_rlast;      lsu_rid   = s_rid;       s_rready  = lsu_rready;
      end
      ST_LSU_WR: begin
        s_awvalid   = lsu_awvalid;  s_awaddr  = lsu_awaddr;  s_awid    = lsu_awid;
        s_awlen     = lsu_awlen;    s_awsize  = lsu_awsize;  s_awburst = lsu_awburst;
        lsu_awready = s_awready;
        s_wvalid    = lsu_wvalid;   s_wdata   = lsu_wdata;   s_wstrb   = lsu_wstrb;
        s_wlast     = lsu_wlast;    lsu_wready = s_wready;
        lsu_bvalid  = s_bvalid;     lsu_bresp = s_bresp;     lsu_bid   = s_bid;
        s_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed vector bench for the IFU/LSU AXI arbiter.
module tb_ysyx_25020037_axi_arbiter;
  import ysyx_25020037_axi_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [3:0]  ifu_arid, ifu_rid;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst, ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [3:0]  lsu_arid, lsu_rid;
  logic [7:0]  lsu_arlen;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_arburst, lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_awid, lsu_bid, lsu_wstrb;
  logic [7:0]  lsu_awlen;
  logic [2:0]  lsu_awsize;
  logic [1:0]  lsu_awburst, lsu_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_bid, s_wstrb;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;
  logic [31:0] contention_cnt;

  ysyx_25020037_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast),
    .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata), .lsu_rlast(lsu_rlast),
    .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
    .lsu_bready(lsu_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_bready(s_bready), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  // in  = {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, s_arready, s_rvalid, s_rlast, s_aw/wready, s_bvalid}
  // out = {s_arvalid, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, s_awvalid, s_wvalid, lsu_bvalid}
  typedef struct packed {
    logic [8:0]  in;
    logic [7:0]  out;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [8:0] i, input logic [7:0] o, input logic [31:0] c);
    vec_t v;
    v.in = i; v.out = o; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input int idx, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %0h want %0h", idx, nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {s_arvalid, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, s_awvalid, s_wvalid, lsu_bvalid};
  endfunction

  // Called at a negedge: drive, settle, compare, advance to the next negedge.
  task automatic step(input vec_t v, input int idx);
    {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, s_arready, s_rvalid, s_rlast} = v.in[8:2];
    s_awready = v.in[1];
    s_wready  = v.in[1];
    s_bvalid  = v.in[0];
    #2;
    chk(idx, "valid_ready", {56'd0, outs()}, {56'd0, v.out});
    chk(idx, "contention_cnt", {32'd0, contention_cnt}, {32'd0, v.cnt});
    if (v.out[7])
      chk(idx, "s_ar_payload", {20'd0, s_araddr, s_arid, s_arlen},
          v.out[6] ? {20'd0, 32'h3000_0000, 4'h1, 8'd3} : {20'd0, 32'h8000_0010, 4'h2, 8'd0});
    if (v.out[5]) chk(idx, "ifu_r_payload", {26'd0, ifu_rdata, ifu_rid, ifu_rresp}, {26'd0, 32'h1234_5678, 4'h3, 2'b00});
    if (v.out[3]) chk(idx, "lsu_r_payload", {26'd0, lsu_rdata, lsu_rid, lsu_rresp}, {26'd0, 32'h1234_5678, 4'h3, 2'b00});
    if (v.out[2]) chk(idx, "s_aw_payload", {28'd0, s_awaddr, s_awid}, {28'd0, 32'hA000_0004, 4'h4});
    if (v.out[1]) chk(idx, "s_w_payload", {27'd0, s_wdata, s_wstrb, s_wlast}, {27'd0, 32'hDEAD_BEEF, 4'b1100, 1'b1});
    if (v.out[0]) chk(idx, "lsu_b_payload", {58'd0, lsu_bid, lsu_bresp}, {58'd0, 4'h5, 2'b10});
    @(negedge clk);
  endtask

  initial begin
    ifu_araddr = 32'h3000_0000; ifu_arid = 4'h1; ifu_arlen = 8'd3; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    lsu_araddr = 32'h8000_0010; lsu_arid = 4'h2; lsu_arlen = 8'd0; lsu_arsize = 3'd2; lsu_arburst = 2'b01;
    lsu_awaddr = 32'hA000_0004; lsu_awid = 4'h4; lsu_awlen = 8'd0; lsu_awsize = 3'd2; lsu_awburst = 2'b01;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b1100; lsu_wlast = 1'b1;
    ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
    s_rdata = 32'h1234_5678; s_rresp = RESP_OKAY; s_rid = 4'h3; s_bresp = RESP_SLVERR; s_bid = 4'h5;
    {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, s_arready, s_rvalid, s_rlast} = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;

    // IFU-only single read
    tbl.push_back(mk(9'b000000000, 8'b00000000, 0));
    tbl.push_back(mk(9'b100010000, 8'b00000000, 0));
    tbl.push_back(mk(9'b100010000, 8'b11000000, 0));
    tbl.push_back(mk(9'b000001100, 8'b00100000, 0));
    tbl.push_back(mk(9'b000000000, 8'b00000000, 0));
    // IFU/LSU tie: LSU first, IFU waits and is counted
    tbl.push_back(mk(9'b110000000, 8'b00000000, 0));
    tbl.push_back(mk(9'b110010000, 8'b10010000, 1));
    tbl.push_back(mk(9'b100001000, 8'b00001000, 2));
    tbl.push_back(mk(9'b100001100, 8'b00001000, 3));
    tbl.push_back(mk(9'b100000000, 8'b00000000, 4));
    tbl.push_back(mk(9'b100010000, 8'b11000000, 4));
    tbl.push_back(mk(9'b000001100, 8'b00100000, 4));
    tbl.push_back(mk(9'b000000000, 8'b00000000, 4));
    // LSU write with SLVERR response
    tbl.push_back(mk(9'b001100000, 8'b00000000, 4));
    tbl.push_back(mk(9'b001100010, 8'b00000110, 4));
    tbl.push_back(mk(9'b000000001, 8'b00000001, 4));
    tbl.push_back(mk(9'b000000000, 8'b00000000, 4));
    // IFU 4-beat burst with LSU read pending throughout
    tbl.push_back(mk(9'b110000000, 8'b00000000, 4));
    tbl.push_back(mk(9'b110010000, 8'b11000000, 5));
    tbl.push_back(mk(9'b010001000, 8'b00100000, 6));
    tbl.push_back(mk(9'b010001000, 8'b00100000, 7));
    tbl.push_back(mk(9'b010001000, 8'b00100000, 8));
    tbl.push_back(mk(9'b010001100, 8'b00100000, 9));
    tbl.push_back(mk(9'b010000000, 8'b00000000, 10));
    tbl.push_back(mk(9'b010010000, 8'b10010000, 10));
    tbl.push_back(mk(9'b000001100, 8'b00001000, 10));
    tbl.push_back(mk(9'b000000000, 8'b00000000, 10));
    // LSU AR+AW together: write wins
    tbl.push_back(mk(9'b011100000, 8'b00000000, 10));
    tbl.push_back(mk(9'b011100010, 8'b00000110, 10));
    tbl.push_back(mk(9'b000000001, 8'b00000001, 10));
    tbl.push_back(mk(9'b000000000, 8'b00000000, 10));

    // reset state
    repeat (2) @(negedge clk);
    chk(-1, "reset_outs", {56'd0, outs()}, 64'd0);
    chk(-1, "reset_cnt", {32'd0, contention_cnt}, 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i], i);

    // back-to-back IFU reads: rlast, one IDLE cycle, then the next grant
    step(mk(9'b100010000, 8'b00000000, 10), 100);
    step(mk(9'b100010000, 8'b11000000, 10), 101);
    step(mk(9'b000001100, 8'b00100000, 10), 102);
    step(mk(9'b100010000, 8'b00000000, 10), 103);
    step(mk(9'b100010000, 8'b11000000, 10), 104);
    step(mk(9'b000001100, 8'b00100000, 10), 105);

    // reset in the middle of an IFU burst
    step(mk(9'b100010000, 8'b00000000, 10), 200);
    step(mk(9'b100010000, 8'b11000000, 10), 201);
    step(mk(9'b010001000, 8'b00100000, 10), 202);
    {ifu_arvalid, lsu_arvalid, s_arready, s_rvalid} = 4'b1111;
    #1;
    chk(203, "pre_rst_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd1);
    rst = 1'b1;
    #1;
    chk(204, "rst_outs", {54'd0, outs(), s_rready, s_bready}, 64'd0);
    chk(204, "rst_cnt", {32'd0, contention_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // last_grant back to IFU, so the tie goes to LSU
    step(mk(9'b110010000, 8'b00000000, 0), 205);
    step(mk(9'b110010000, 8'b10010000, 1), 206);
    step(mk(9'b100001100, 8'b00001000, 2), 207);
    step(mk(9'b100000000, 8'b00000000, 3), 208);
    step(mk(9'b100010000, 8'b11000000, 3), 209);
    step(mk(9'b000001100, 8'b00100000, 3), 210);
    step(mk(9'b000000000, 8'b00000000, 3), 211);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
